oven_ctrl: RTL and testbench

OVEN_CTRL -- requirements
Module: oven_ctrl

---
 rtl/oven_pkg.sv | 25 ++
 rtl/oven_ctrl_tick_gen.sv | 29 ++
 rtl/oven_ctrl.sv | 131 +++++++++++++
 tb/tb_oven_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared types and constants for the microwave oven controller.
// The debug struct lets checkers observe FSM state and digit count without probing internals.
package oven_pkg;

    localparam int MAX_DIGITS  = 3;
    localparam int DIGIT_CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } oven_state_t;

    typedef struct packed {
        oven_state_t             state;
        logic [DIGIT_CNT_W-1:0]  digit_cnt;
    } oven_dbg_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/oven_ctrl_tick_gen.sv
// One-second prescaler: emits a one-cycle tick every CLK_DIV cycles while run is high.
// Dropping run clears the count, so each run period starts a full CLK_DIV interval.
module tick_gen #(
    parameter int CLK_DIV = 50000000
) (
    input  logic clock,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (clr || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/oven_ctrl.sv
// Microwave oven controller: keypad entry, cook/pause/done sequencing and timer strobes.
// Handshake: key_valid/start/stop are single-cycle pulses sampled on the rising clock edge; no backpressure.
module oven_ctrl
    import oven_pkg::*;
#(
    parameter int CLK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       clrn,
    output logic       enable,
    output logic       mag_on,
    output logic       done,
    output oven_dbg_t  dbg
);

    oven_state_t            state_q;
    oven_state_t            state_d;
    logic [DIGIT_CNT_W-1:0] digit_cnt_q;
    logic [DIGIT_CNT_W-1:0] digit_cnt_d;
    logic [3:0]             data_d;
    logic                   loadn_d;
    logic                   clrn_d;
    logic                   enable_d;
    logic                   mag_on_d;
    logic                   done_d;
    logic                   clear_d;
    logic                   key_ok;
    logic                   tick;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .clr   (clr),
        .run   (state_q == COOK),
        .tick  (tick)
    );

    assign key_ok = key_valid && is_digit(key_code)
                 && (digit_cnt_q < DIGIT_CNT_W'(MAX_DIGITS));

    // Within IDLE/ENTRY the order is stop, then start, then key; a start that
    // cannot begin cooking still swallows a key pressed in the same cycle.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        data_d      = data;
        loadn_d     = 1'b1;
        case (state_q)
            IDLE, ENTRY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    if (state_q == ENTRY && door_closed && !timer_zero) begin
                        state_d = COOK;
                    end
                end else if (key_ok) begin
                    state_d     = ENTRY;
                    digit_cnt_d = digit_cnt_q + 1'b1;
                    data_d      = key_code;
                    loadn_d     = 1'b0;
                end
            end
            COOK: begin
                if (timer_zero) begin
                    state_d = DONE;
                end else if (stop || !door_closed) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (stop || !door_closed || key_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        clear_d = (state_d == IDLE) && (state_q != IDLE);
        if (clear_d) begin
            digit_cnt_d = '0;
        end
        clrn_d   = !clear_d;
        mag_on_d = (state_d == COOK);
        done_d   = (state_d == DONE);
        // Only count down while staying in COOK with time left on the clock.
        enable_d = tick && (state_q == COOK) && (state_d == COOK)
                && !timer_zero && loadn_d;
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state_q     <= IDLE;
            digit_cnt_q <= '0;
            data        <= 4'd0;
            loadn       <= 1'b1;
            clrn        <= 1'b0;
            enable      <= 1'b0;
            mag_on      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            data        <= data_d;
            loadn       <= loadn_d;
            clrn        <= clrn_d;
            enable      <= enable_d;
            mag_on      <= mag_on_d;
            done        <= done_d;
        end
    end

    assign dbg = '{state: state_q, digit_cnt: digit_cnt_q};

endmodule

// File: tb/tb_oven_ctrl.sv
// Directed plus randomized bench for oven_ctrl with a decimal countdown timer model.
// Expected loads, pulse counts and timings come from the oven's behavioural rules.
module tb_oven_ctrl;
    import oven_pkg::*;

    localparam int DIV = 4;

    logic       clock;
    logic       clr;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       clrn;
    logic       enable;
    logic       mag_on;
    logic       done;
    oven_dbg_t  dbg;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int         tval = 0;
    int         en_cnt = 0;
    logic [3:0] load_got[$];

    oven_ctrl #(.CLK_DIV(DIV)) dut (
        .clock       (clock),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .data        (data),
        .loadn       (loadn),
        .clrn        (clrn),
        .enable      (enable),
        .mag_on      (mag_on),
        .done        (done),
        .dbg         (dbg)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural countdown timer: digits shift in as decimal, clear to zero, count down on enable.
    always @(posedge clock) begin
        if (clrn === 1'b0) tval <= 0;
        else if (loadn === 1'b0) tval <= (tval * 10 + int'(data)) % 1000;
        else if (enable === 1'b1 && tval > 0) tval <= tval - 1;
    end
    assign timer_zero = (tval == 0);

    always @(posedge clock) begin
        if (loadn === 1'b0) load_got.push_back(data);
        if (enable === 1'b1) en_cnt <= en_cnt + 1;
    end

    // driver tasks
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_q[$];
        int         base;
        int         en_base;
        int         value;
        int         nkeys;
        logic [3:0] code;

        clr = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b1;

        // Reset held for three cycles
        tick(3);
        chk("rst_clrn", 32'(clrn), 32'd0);
        chk("rst_loadn", 32'(loadn), 32'd1);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_mag_on", 32'(mag_on), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_state", 32'(dbg.state), 32'(IDLE));
        chk("rst_digits", 32'(dbg.digit_cnt), 32'd0);
        clr = 1'b0;
        tick();
        chk("rst_clrn_release", 32'(clrn), 32'd1);

        // Entry: 1,3,0 load, 7 is the fourth digit and is ignored
        base = load_got.size();
        pulse_key(4'd1);
        chk("entry_state", 32'(dbg.state), 32'(ENTRY));
        chk("entry_loadn_low", 32'(loadn), 32'd0);
        tick();
        chk("entry_loadn_one_cycle", 32'(loadn), 32'd1);
        pulse_key(4'd3); tick();
        pulse_key(4'd0); tick();
        pulse_key(4'd7);
        chk("entry_fourth_no_load", 32'(loadn), 32'd1);
        tick();
        chk("entry_load_count", 32'(load_got.size() - base), 32'd3);
        exp_q = '{4'd1, 4'd3, 4'd0};
        for (int i = 0; i < 3 && base + i < load_got.size(); i++)
            chk("entry_load_data", 32'(load_got[base + i]), 32'(exp_q[i]));

        // Stop in ENTRY clears back to IDLE with a single clrn strobe
        press_stop();
        chk("entry_stop_state", 32'(dbg.state), 32'(IDLE));
        chk("entry_stop_clrn", 32'(clrn), 32'd0);
        tick();
        chk("entry_stop_clrn_release", 32'(clrn), 32'd1);

        // Start with timer at zero, then with door open: both ignored
        pulse_key(4'd0); tick();
        press_start();
        chk("start_tz_ignored", 32'(dbg.state), 32'(ENTRY));
        pulse_key(4'd2); tick();
        door_closed = 1'b0;
        press_start();
        chk("start_door_open_ignored", 32'(dbg.state), 32'(ENTRY));
        door_closed = 1'b1;

        // Cook 0:02
        en_base = en_cnt;
        press_start();
        chk("cook_state", 32'(dbg.state), 32'(COOK));
        chk("cook_mag_on", 32'(mag_on), 32'd1);
        for (int t = 1; t <= 2 * DIV; t++) begin
            tick();
            chk("cook_enable", 32'(enable), 32'(t % DIV == 0));
        end
        wait_done(6);
        chk("done_mag_off", 32'(mag_on), 32'd0);
        chk("done_state", 32'(dbg.state), 32'(DONE));
        chk("done_enable_pulses", 32'(en_cnt - en_base), 32'd2);

        // A key in DONE returns to IDLE
        pulse_key(4'd4);
        chk("done_key_state", 32'(dbg.state), 32'(IDLE));
        chk("done_key_clrn", 32'(clrn), 32'd0);
        chk("done_key_no_load", 32'(loadn), 32'd1);
        chk("done_key_done_low", 32'(done), 32'd0);
        tick();

        // Door opened mid-COOK, then resumed with a fresh prescale
        pulse_key(4'd5); tick();
        press_start();
        tick(6);
        door_closed = 1'b0;
        tick();
        chk("door_pause_state", 32'(dbg.state), 32'(PAUSE));
        chk("door_pause_mag", 32'(mag_on), 32'd0);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("pause_enable_low", 32'(enable), 32'd0);
        end
        chk("pause_timer_held", 32'(tval), 32'd4);
        door_closed = 1'b1;
        press_start();
        chk("resume_state", 32'(dbg.state), 32'(COOK));
        for (int t = 1; t <= DIV; t++) begin
            tick();
            chk("resume_enable", 32'(enable), 32'(t == DIV));
        end

        // Stop in COOK pauses, stop in PAUSE clears
        press_stop();
        chk("cook_stop_pause", 32'(dbg.state), 32'(PAUSE));
        press_stop();
        chk("pause_stop_idle", 32'(dbg.state), 32'(IDLE));
        chk("pause_stop_clrn", 32'(clrn), 32'd0);
        tick();
        chk("pause_stop_clrn_single", 32'(clrn), 32'd1);

        // timer_zero and stop in the same COOK cycle: DONE wins
        pulse_key(4'd1); tick();
        press_start();
        tick(DIV + 1);
        chk("simul_tz_seen", 32'(timer_zero), 32'd1);
        press_stop();
        chk("simul_done_state", 32'(dbg.state), 32'(DONE));
        chk("simul_done_flag", 32'(done), 32'd1);
        press_stop();
        tick();

        // clr mid-COOK drops the heater on the next edge
        pulse_key(4'd3); tick();
        press_start();
        tick(2);
        clr = 1'b1;
        tick();
        chk("clr_cook_mag", 32'(mag_on), 32'd0);
        chk("clr_cook_clrn", 32'(clrn), 32'd0);
        chk("clr_cook_state", 32'(dbg.state), 32'(IDLE));
        clr = 1'b0;
        tick();
        chk("clr_cook_release", 32'(clrn), 32'd1);

        // Randomized key entry and cook runs
        for (int it = 0; it < 6; it++) begin
            exp_q.delete();
            base    = load_got.size();
            nkeys   = $urandom_range(1, 6);
            for (int k = 0; k < nkeys; k++) begin
                code = 4'($urandom_range(0, 15));
                pulse_key(code);
                if (code <= 4'd9 && exp_q.size() < MAX_DIGITS) exp_q.push_back(code);
                tick($urandom_range(0, 2));
            end
            tick();
            chk("rnd_load_count", 32'(load_got.size() - base), 32'(exp_q.size()));
            value = 0;
            foreach (exp_q[i]) begin
                value = value * 10 + int'(exp_q[i]);
                if (base + i < load_got.size())
                    chk("rnd_load_data", 32'(load_got[base + i]), 32'(exp_q[i]));
            end
            chk("rnd_state", 32'(dbg.state), exp_q.size() > 0 ? 32'(ENTRY) : 32'(IDLE));
            if (value > 0) begin
                en_base = en_cnt;
                press_start();
                wait_done(value * DIV + 2 * DIV + 4);
                chk("rnd_enable_pulses", 32'(en_cnt - en_base), 32'(value));
                press_stop();
            end else if (exp_q.size() > 0) begin
                press_start();
                chk("rnd_zero_start_ignored", 32'(dbg.state), 32'(ENTRY));
                press_stop();
            end
            tick(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
